// File: rtl/wallace_mul16_seq_if.sv
// Operand request / result response bundle for the 16x16 sequential multiplier.
// The requester drives the operand side and consumes the result side.
interface wallace_mul16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_prod;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );
endinterface

// File: rtl/wallace_mul16_seq.sv
// 16x16 unsigned multiplier built from one shared 8x8 Wallace core.
// The four byte-wise partial products are issued one per cycle and
// shift-accumulated into a 32-bit result returned over valid/ready.

// Combinational 8x8 unsigned multiplier: carry-save tree, 8 rows -> 2, then one add.
module wallace_8x8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  logic [7:0][15:0] w_pp;
  logic [31:0]      w_l1a, w_l1b, w_l2a, w_l2b, w_l3, w_l4;

  // 3:2 compressor on whole rows; returns {sum, carry<<1}. Partial sums never
  // exceed the 16-bit product, so the carry shifted past bit 15 is always 0.
  function automatic logic [31:0] f_csa(input logic [15:0] x, y, z);
    logic [15:0] m;
    m = (x & y) | (x & z) | (y & z);
    return {x ^ y ^ z, m[14:0], 1'b0};
  endfunction

  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign w_pp[i] = {8'b0, i_a & {8{i_b[i]}}} << i;
  end

  // Reduction: 8 -> 6 -> 4 -> 3 -> 2 rows, then carry-propagate add.
  always_comb begin
    w_l1a = f_csa(w_pp[0], w_pp[1], w_pp[2]);
    w_l1b = f_csa(w_pp[3], w_pp[4], w_pp[5]);
    w_l2a = f_csa(w_l1a[31:16], w_l1a[15:0], w_l1b[31:16]);
    w_l2b = f_csa(w_l1b[15:0], w_pp[6], w_pp[7]);
    w_l3  = f_csa(w_l2a[31:16], w_l2a[15:0], w_l2b[31:16]);
    w_l4  = f_csa(w_l3[31:16], w_l3[15:0], w_l2b[15:0]);
    o_p   = w_l4[31:16] + w_l4[15:0];
  end
endmodule

module wallace_mul16_seq #(
  parameter bit EARLY_ZERO = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  wallace_mul16_seq_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_P3, S_DONE} state_t;

  state_t           r_state;
  logic [15:0]      r_a, r_b;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       w_ca, w_cb;
  logic [15:0]      w_pp;
  logic [31:0]      w_term;
  logic             w_zero;

  wallace_8x8 u_core (.i_a(w_ca), .i_b(w_cb), .o_p(w_pp));

  assign w_zero = (EARLY_ZERO != 1'b0) && ((bus.in_a == 16'd0) || (bus.in_b == 16'd0));

  // Select the byte pair for this cycle's partial product and its weight in acc.
  always_comb begin
    w_ca   = 8'd0;
    w_cb   = 8'd0;
    w_term = 32'd0;
    case (r_state)
      S_P0: begin w_ca = r_a[7:0];  w_cb = r_b[7:0];  w_term = {16'd0, w_pp};       end
      S_P1: begin w_ca = r_a[7:0];  w_cb = r_b[15:8]; w_term = {8'd0, w_pp, 8'd0};  end
      S_P2: begin w_ca = r_a[15:8]; w_cb = r_b[7:0];  w_term = {8'd0, w_pp, 8'd0};  end
      S_P3: begin w_ca = r_a[15:8]; w_cb = r_b[15:8]; w_term = {w_pp, 16'd0};       end
      default: ;
    endcase
  end

  // Sequencer: accept, four accumulate cycles (or skip on a zero operand), hold until handoff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= 16'd0;
      r_b     <= 16'd0;
      r_acc   <= 32'd0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_a     <= bus.in_a;
          r_b     <= bus.in_b;
          r_acc   <= 32'd0;
          r_state <= w_zero ? S_DONE : S_P0;
        end
        S_P0: begin r_acc <= r_acc + w_term; r_state <= S_P1;   end
        S_P1: begin r_acc <= r_acc + w_term; r_state <= S_P2;   end
        S_P2: begin r_acc <= r_acc + w_term; r_state <= S_P3;   end
        S_P3: begin r_acc <= r_acc + w_term; r_state <= S_DONE; end
        S_DONE: if (bus.out_ready) begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_prod  = r_acc;
  assign busy          = (r_state != S_IDLE);
  assign op_count      = r_cnt;
endmodule
